signed_adder_tree: RTL and testbench

- Pipelined, parametrised N-input signed adder with per-channel runtime add/subtract selection and a valid/ready stream handshake.
- Full bit growth is guaranteed for all legal inputs, including negation of the most-negative value.
- Sits in datapaths such as FIR tap summation, beamformer channel combining and correlator outputs, where the purely combinational two-input adder does not meet timing or cannot scale.

---
 rtl/signed_adder_tree_if.sv | 26 ++
 rtl/signed_adder_tree.sv | 85 ++++++++
 tb/tb_signed_adder_tree.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_adder_tree_if.sv
// Stream bundle for signed_adder_tree: packed channels in,
// signed sum out, valid/ready on both sides.
interface signed_adder_tree_if #(
    parameter int IWIDTH = 16,
    parameter int NCH    = 4
);
    localparam int OWIDTH = IWIDTH + $clog2(NCH) + 1;

    logic [NCH*IWIDTH-1:0] i_data;
    logic [NCH-1:0]        i_neg;
    logic                  i_valid;
    logic                  o_ready;
    logic signed [OWIDTH-1:0] o_sum;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output i_data, i_neg, i_valid, i_ready,
        input  o_ready, o_sum, o_valid
    );

    modport slave (
        input  i_data, i_neg, i_valid, i_ready,
        output o_ready, o_sum, o_valid
    );
endinterface

// File: rtl/signed_adder_tree.sv
// Pipelined N-input signed adder tree with per-channel
// add/subtract select and a globally stalled valid/ready pipe.
module signed_adder_tree #(
    parameter int IWIDTH = 16,
    parameter int NCH    = 4
) (
    input logic                i_clk,
    input logic                i_rst_n,
    signed_adder_tree_if.slave bus
);
    localparam int LVL    = $clog2(NCH);
    localparam int OWIDTH = IWIDTH + LVL + 1;
    localparam int LAT    = LVL + 1;

    function automatic int cnt(input int l);
        return (NCH + (1 << l) - 1) >> l;
    endfunction

    logic           en;
    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;

    assign en          = ~vld_q[LAT-1] | bus.i_ready;
    assign bus.o_ready = en;
    assign bus.o_valid = vld_q[LAT-1];
    assign vld_d       = {vld_q[LAT-2:0], bus.i_valid};

    // valid bits march with the data and freeze with it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) vld_q <= '0;
        else if (en)  vld_q <= vld_d;
    end

    for (genvar l = 0; l <= LVL; l++) begin : g_lv
        localparam int CNT = cnt(l);
        logic [CNT*OWIDTH-1:0] v_d;
        logic [CNT*OWIDTH-1:0] v_q;

        if (l == 0) begin : g_in
            // sign-extend each channel, negate where selected
            always_comb begin
                logic signed [OWIDTH-1:0] ext;
                ext = '0;
                v_d = '0;
                for (int k = 0; k < NCH; k++) begin
                    ext = {{(OWIDTH-IWIDTH){
                        bus.i_data[k*IWIDTH+IWIDTH-1]}},
                        bus.i_data[k*IWIDTH +: IWIDTH]};
                    v_d[k*OWIDTH +: OWIDTH] =
                        bus.i_neg[k] ? -ext : ext;
                end
            end
        end else begin : g_add
            localparam int PCNT = cnt(l-1);
            logic [PCNT*OWIDTH-1:0] p;
            assign p = g_lv[l-1].v_q;

            // pairwise sums; a lone top element is carried through
            always_comb begin
                v_d = '0;
                for (int j = 0; j < CNT-1; j++) begin
                    v_d[j*OWIDTH +: OWIDTH] =
                        p[2*j*OWIDTH +: OWIDTH] +
                        p[(2*j+1)*OWIDTH +: OWIDTH];
                end
                if (PCNT % 2 == 1) begin
                    v_d[(CNT-1)*OWIDTH +: OWIDTH] =
                        p[(PCNT-1)*OWIDTH +: OWIDTH];
                end else begin
                    v_d[(CNT-1)*OWIDTH +: OWIDTH] =
                        p[(PCNT-2)*OWIDTH +: OWIDTH] +
                        p[(PCNT-1)*OWIDTH +: OWIDTH];
                end
            end
        end

        // stage register, held while the output is stalled
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) v_q <= '0;
            else if (en)  v_q <= v_d;
        end
    end

    assign bus.o_sum = g_lv[LVL].v_q;
endmodule

// File: tb/tb_signed_adder_tree.sv
// Self-checking bench: directed vectors, NCH=5 corner,
// streaming with random backpressure, reset mid-stream.
module tb_signed_adder_tree;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    signed_adder_tree_if #(.IWIDTH(16), .NCH(4)) a();
    signed_adder_tree_if #(.IWIDTH(8),  .NCH(5)) b();

    signed_adder_tree #(.IWIDTH(16), .NCH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(a.slave)
    );
    signed_adder_tree #(.IWIDTH(8), .NCH(5)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b.slave)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  neg;
        longint      exp;
    } vec_t;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ref4(input logic [63:0] d,
                                    input logic [3:0] n);
        longint s = 0;
        for (int k = 0; k < 4; k++) begin
            logic signed [15:0] c;
            longint x;
            c = d[k*16 +: 16];
            x = c;
            s += n[k] ? -x : x;
        end
        return s;
    endfunction

    function automatic longint ref5(input logic [39:0] d,
                                    input logic [4:0] n);
        longint s = 0;
        for (int k = 0; k < 5; k++) begin
            logic signed [7:0] c;
            longint x;
            c = d[k*8 +: 8];
            x = c;
            s += n[k] ? -x : x;
        end
        return s;
    endfunction

    function automatic logic [63:0] rnd4();
        logic [63:0] d;
        for (int k = 0; k < 4; k++) begin
            d[k*16 +: 16] = ($urandom_range(0, 7) == 0) ?
                16'h8000 : 16'($urandom);
        end
        return d;
    endfunction

    task automatic beat4(input logic [63:0] d, input logic [3:0] n,
                         input longint exp, input string nm);
        a.i_data = d; a.i_neg = n; a.i_valid = 1'b1; a.i_ready = 1'b1;
        #1;
        chk({nm, "_rdy"}, a.o_ready, 1);
        tick();
        a.i_valid = 1'b0; a.i_data = 'x; a.i_neg = 'x;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("%s_vld%0d", nm, k), a.o_valid, (k == 3));
            if (k == 3) chk({nm, "_sum"}, a.o_sum, exp);
            if (k < 4) tick();
        end
    endtask

    task automatic beat5(input logic [39:0] d, input logic [4:0] n,
                         input longint exp, input string nm);
        b.i_data = d; b.i_neg = n; b.i_valid = 1'b1; b.i_ready = 1'b1;
        #1;
        chk({nm, "_rdy"}, b.o_ready, 1);
        tick();
        b.i_valid = 1'b0; b.i_data = 'x; b.i_neg = 'x;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("%s_vld%0d", nm, k), b.o_valid, (k == 4));
            if (k == 4) chk({nm, "_sum"}, b.o_sum, exp);
            if (k < 5) tick();
        end
    endtask

    task automatic stream(input int nbeats, input bit rnd,
                          input string nm);
        longint      q[$];
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        bit          have = 0;
        bit          hold = 0;
        bit          en_m;
        longint      held = 0;
        logic [63:0] d = '0;
        logic [3:0]  n = '0;
        while (got < nbeats && cyc < 3000) begin
            if (hold) begin
                chk({nm, "_hold_vld"}, a.o_valid, 1);
                chk({nm, "_hold_sum"}, a.o_sum, held);
            end
            if (!have && sent < nbeats &&
                (!rnd || $urandom_range(0, 3) != 0)) begin
                if (rnd) begin
                    d = rnd4();
                    n = 4'($urandom);
                end else begin
                    d = {16'(4*(sent+1)), 16'(3*(sent+1)),
                         16'(2*(sent+1)), 16'(sent+1)};
                    n = 4'(sent);
                end
                have = 1;
            end
            a.i_valid = have;
            a.i_data  = d;
            a.i_neg   = n;
            a.i_ready = ($urandom_range(0, 2) != 0);
            #1;
            en_m = !a.o_valid || a.i_ready;
            chk({nm, "_rdy"}, a.o_ready, en_m);
            if (a.o_valid && a.i_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s_extra: got sum %0d expected none",
                             nm, a.o_sum);
                end else begin
                    chk({nm, "_sum"}, a.o_sum, q.pop_front());
                end
                got++;
            end
            hold = a.o_valid && !a.i_ready;
            held = a.o_sum;
            if (have && en_m) begin
                q.push_back(ref4(d, n));
                sent++;
                have = 0;
            end
            tick();
            cyc++;
        end
        chk({nm, "_count"}, got, nbeats);
        a.i_valid = 1'b0; a.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk({nm, "_drain"}, a.o_valid, 0);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tv[4];
        logic [63:0] d;
        logic [39:0] d5;
        logic [3:0]  n;
        logic [4:0]  n5;

        tv[0] = '{{16'd4, 16'd3, 16'd2, 16'd1}, 4'b0000, 10};
        tv[1] = '{{4{16'h8000}}, 4'b1111, 131072};
        tv[2] = '{{4{16'h8000}}, 4'b0000, -131072};
        tv[3] = '{{16'd400, 16'd300, 16'd200, 16'd100}, 4'b0101, 200};

        rst_n = 1'b0;
        a.i_data = '0; a.i_neg = '0; a.i_valid = 1'b0; a.i_ready = 1'b0;
        b.i_data = '0; b.i_neg = '0; b.i_valid = 1'b0; b.i_ready = 1'b0;
        tick();
        tick();
        chk("rst_vld4", a.o_valid, 0);
        chk("rst_sum4", a.o_sum, 0);
        chk("rst_vld5", b.o_valid, 0);
        chk("rst_sum5", b.o_sum, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy4", a.o_ready, 1);
        chk("rst_rdy5", b.o_ready, 1);
        b.i_ready = 1'b1;
        tick();

        for (int i = 0; i < 4; i++)
            beat4(tv[i].data, tv[i].neg, tv[i].exp,
                  $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            d = rnd4();
            n = 4'($urandom);
            beat4(d, n, ref4(d, n), $sformatf("rnd4_%0d", i));
        end

        beat5({5{8'd127}}, 5'b00000, 635, "n5_max");
        beat5({5{8'h80}}, 5'b11111, 640, "n5_negmin");
        for (int i = 0; i < 4; i++) begin
            d5 = {8'($urandom), 32'($urandom)};
            n5 = 5'($urandom);
            beat5(d5, n5, ref5(d5, n5), $sformatf("rnd5_%0d", i));
        end

        stream(20, 1'b0, "seq");
        stream(150, 1'b1, "rnd");

        a.i_ready = 1'b1; a.i_neg = '0; a.i_valid = 1'b1;
        a.i_data = {16'd1, 16'd1, 16'd1, 16'd1};
        tick();
        a.i_data = {16'd2, 16'd2, 16'd2, 16'd2};
        tick();
        a.i_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_vld", a.o_valid, 0);
        chk("mid_rst_sum", a.o_sum, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("mid_stale%0d", k), a.o_valid, 0);
        end
        d = {16'd7, 16'hfff0, 16'd300, 16'h8000};
        beat4(d, 4'b1010, ref4(d, 4'b1010), "post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
